// File: rtl/pixel_stream_ctrl_pkg.sv
// Shared types and constants for the pixel stream controller: FSM state
// encoding, pixel width and counter sizing helpers.
package pixel_ctrl_pkg;

    localparam int PIX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int frame_size(input int w, input int h);
        return w * h;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pixel_stream_ctrl_if.sv
// Downstream pixel stream: valid/ready handshake plus frame/line markers that
// qualify the pixel currently presented.
interface pixel_stream_ctrl_if;
    import pixel_ctrl_pkg::*;

    logic [PIX_W-1:0] pixel;
    logic             valid;
    logic             ready;
    logic             sof;
    logic             eol;
    logic             eof;

    modport master (output pixel, valid, sof, eol, eof, input ready);
    modport slave  (input pixel, valid, sof, eol, eof, output ready);

endinterface

// File: rtl/pixel_stream_ctrl_fifo.sv
// psc_fifo: synchronous first-word-fall-through FIFO; the head entry is visible
// on dout whenever empty is low. DEPTH must be a power of two.
module psc_fifo
    import pixel_ctrl_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter int  WIDTH = PIX_W,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A pop in the same cycle frees the slot a full FIFO would otherwise refuse.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: storage is not reset; count and pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/pixel_stream_ctrl.sv
// pixel_stream_ctrl: paces the image producer, buffers its pixels and re-times
// them downstream with SOF/EOL/EOF markers. Optional macro: PSC_STALL_CNT_EN.
module pixel_stream_ctrl
    import pixel_ctrl_pkg::*;
#(
    parameter int IMG_W      = 32,
    parameter int IMG_H      = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int FCNT_W     = 16
) (
    input  logic              sensor_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              continuous,
    output logic              prod_ready,
    input  logic [PIX_W-1:0]  prod_pixel,
    input  logic              prod_valid,
    pixel_stream_ctrl_if.master m,
    output logic              busy,
    output logic [FCNT_W-1:0] frame_count,
    output logic              overflow_err,
    output logic [31:0]       stall_cycles
);

    localparam int FRAME  = frame_size(IMG_W, IMG_H);
    localparam int REQ_W  = cnt_w(FRAME);
    localparam int COL_W  = cnt_w(IMG_W);
    localparam int ROW_W  = cnt_w(IMG_H);
    localparam int QW     = $clog2(FIFO_DEPTH) + 1;

    localparam logic [REQ_W-1:0] REQ_LAST = REQ_W'(FRAME - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    state_t             state;
    state_t             state_nxt;
    logic               ready_q;
    logic               stop_pending;
    logic [REQ_W-1:0]   req_cnt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;
    logic [QW-1:0]      fifo_count;
    logic [QW:0]        in_flight;
    logic [PIX_W-1:0]   fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic               issue_ok;
    logic               frame_end;
    logic               capture;
    logic               handshake;

    // Requests already issued but not yet captured occupy a FIFO slot in advance.
    assign in_flight = {1'b0, fifo_count} + (QW+1)'(ready_q);
    assign issue_ok  = in_flight < (QW+1)'(FIFO_DEPTH);
    assign capture   = ready_q && prod_valid;
    assign handshake = m.valid && m.ready;

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_nxt  = state;
        prod_ready = 1'b0;
        frame_end  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                prod_ready = issue_ok;
                frame_end  = issue_ok && (req_cnt == REQ_LAST);
                if (frame_end && !(continuous && !stop_pending && !stop)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_empty && !ready_q) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sensor_clk) begin
        if (rst) begin
            state        <= IDLE;
            ready_q      <= 1'b0;
            stop_pending <= 1'b0;
            req_cnt      <= '0;
            col          <= '0;
            row          <= '0;
            frame_count  <= '0;
            overflow_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            ready_q <= prod_ready;

            if (prod_ready) begin
                req_cnt <= frame_end ? '0 : req_cnt + 1'b1;
            end

            if (state == RUN) begin
                if (state_nxt == DRAIN) begin
                    stop_pending <= 1'b0;
                end else if (stop) begin
                    stop_pending <= 1'b1;
                end
            end

            if (capture && fifo_full && !handshake) begin
                overflow_err <= 1'b1;
            end

            if (handshake) begin
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                if (m.eof) begin
                    frame_count <= frame_count + 1'b1;
                end
            end
        end
    end

    psc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PIX_W)
    ) u_fifo (
        .clk   (sensor_clk),
        .rst   (rst),
        .push  (capture),
        .din   (prod_pixel),
        .pop   (handshake),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Outputs are forced to zero while nothing is presented, including after reset.
    assign m.valid = !fifo_empty;
    assign m.pixel = m.valid ? fifo_dout : '0;
    assign m.sof   = m.valid && (col == '0) && (row == '0);
    assign m.eol   = m.valid && (col == COL_LAST);
    assign m.eof   = m.eol && (row == ROW_LAST);
    assign busy    = (state != IDLE);

`ifdef PSC_STALL_CNT_EN
    always_ff @(posedge sensor_clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if (m.valid && !m.ready && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`else
    assign stall_cycles = '0;
`endif

endmodule
